// File: rtl/id_stage_if.sv
// Fetch-to-decode bundle for id_stage: fetch slot, redirect/freeze controls,
// EX-stage hazard info in; decoded fields, controls and stall status out.
//   master : the environment (fetch / EX / register file side)
//   slave  : id_stage
interface id_stage_if;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        flush;
   logic        hold;
   logic [4:0]  ex_rd;
   logic        ex_memread;
   logic        ex_valid;

   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        rf_we;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        jump;
   logic [31:0] imm;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        illegal;
   logic        stall_o;
   logic [15:0] stall_cnt;

   modport master (
      output if_instr, if_pc, if_valid, flush, hold, ex_rd, ex_memread, ex_valid,
      input  rs1, rs2, rd, rf_we, mem_read, mem_write, branch, jump, imm,
             id_pc, id_instr, id_valid, illegal, stall_o, stall_cnt
   );

   modport slave (
      input  if_instr, if_pc, if_valid, flush, hold, ex_rd, ex_memread, ex_valid,
      output rs1, rs2, rd, rf_we, mem_read, mem_write, branch, jump, imm,
             id_pc, id_instr, id_valid, illegal, stall_o, stall_cnt
   );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID pipeline register, combinational
// decode of the registered instruction, load-use hazard detection and a
// saturating stall counter.
//   clk  : processor clock
//   rst  : synchronous active-low reset
//   bus  : id_stage_if.slave (fetch inputs, EX hazard info, decode outputs)
module id_stage (
   input logic        clk,
   input logic        rst,
   id_stage_if.slave  bus
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 16;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;
   logic [CW-1:0]   cnt_q;

   logic [4:0]      rs1_c, rs2_c, rd_c;
   logic            we_c, mr_c, mw_c, br_c, jp_c, legal_c;
   logic            uses_rs1_c, uses_rs2_c;
   logic [XLEN-1:0] imm_c;
   logic            load_use_c;
   logic            bubble_c;

   assign rs1_c = instr_q[19:15];
   assign rs2_c = instr_q[24:20];
   assign rd_c  = instr_q[11:7];

   // Opcode decode and immediate generation from the IF/ID register
   always_comb begin
      we_c       = 1'b0;
      mr_c       = 1'b0;
      mw_c       = 1'b0;
      br_c       = 1'b0;
      jp_c       = 1'b0;
      uses_rs1_c = 1'b0;
      uses_rs2_c = 1'b0;
      legal_c    = 1'b1;
      imm_c      = '0;
      case (instr_q[6:0])
         OP_R: begin
            we_c = 1'b1; uses_rs1_c = 1'b1; uses_rs2_c = 1'b1;
         end
         OP_IALU: begin
            we_c = 1'b1; uses_rs1_c = 1'b1;
            imm_c = {{20{instr_q[31]}}, instr_q[31:20]};
         end
         OP_LOAD: begin
            we_c = 1'b1; mr_c = 1'b1; uses_rs1_c = 1'b1;
            imm_c = {{20{instr_q[31]}}, instr_q[31:20]};
         end
         OP_STORE: begin
            mw_c = 1'b1; uses_rs1_c = 1'b1; uses_rs2_c = 1'b1;
            imm_c = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
         end
         OP_BRANCH: begin
            br_c = 1'b1; uses_rs1_c = 1'b1; uses_rs2_c = 1'b1;
            imm_c = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                     instr_q[30:25], instr_q[11:8], 1'b0};
         end
         OP_JAL: begin
            we_c = 1'b1; jp_c = 1'b1;
            imm_c = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                     instr_q[20], instr_q[30:21], 1'b0};
         end
         OP_JALR: begin
            we_c = 1'b1; jp_c = 1'b1; uses_rs1_c = 1'b1;
            imm_c = {{20{instr_q[31]}}, instr_q[31:20]};
         end
         OP_LUI, OP_AUIPC: begin
            we_c = 1'b1;
            imm_c = {instr_q[31:12], 12'h000};
         end
         default: legal_c = 1'b0;
      endcase
      // Writes to x0 are architecturally discarded
      if (rd_c == 5'd0) we_c = 1'b0;
   end

   // Load-use hazard: consumer in ID needs a register still being loaded in EX
   assign load_use_c = valid_q && bus.ex_valid && bus.ex_memread && (bus.ex_rd != 5'd0) &&
                       ((uses_rs1_c && (rs1_c == bus.ex_rd)) ||
                        (uses_rs2_c && (rs2_c == bus.ex_rd)));

   assign bubble_c = !valid_q || load_use_c || bus.hold || bus.flush;

   // Decode outputs; every side-effecting control is squashed in a bubble
   always_comb begin
      bus.rs1       = rs1_c;
      bus.rs2       = rs2_c;
      bus.rd        = rd_c;
      bus.imm       = imm_c;
      bus.id_pc     = pc_q;
      bus.id_instr  = instr_q;
      bus.stall_cnt = cnt_q;
      bus.stall_o   = (load_use_c || bus.hold) && !bus.flush;
      bus.rf_we     = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.branch    = 1'b0;
      bus.jump      = 1'b0;
      bus.id_valid  = 1'b0;
      bus.illegal   = 1'b0;
      if (!bubble_c) begin
         bus.id_valid = 1'b1;
         bus.illegal  = !legal_c;
         if (legal_c) begin
            bus.rf_we     = we_c;
            bus.mem_read  = mr_c;
            bus.mem_write = mw_c;
            bus.branch    = br_c;
            bus.jump      = jp_c;
         end
      end
   end

   // IF/ID register: reset > flush > stall (keep) > load
   always_ff @(posedge clk) begin
      if (!rst) begin
         instr_q <= NOP;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (bus.flush) begin
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else if (!(load_use_c || bus.hold)) begin
         instr_q <= bus.if_valid ? bus.if_instr : NOP;
         pc_q    <= bus.if_pc;
         valid_q <= bus.if_valid;
      end
   end

   // Saturating count of load-use stall cycles; a flush cancels the stall
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load_use_c && !bus.flush && (cnt_q != {CW{1'b1}})) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk input 1, processor clock (CPU_clk); rst input 1, synchronous active-low reset.
REQ-002 SHALL have inputs: if_instr 32 fetched instruction; if_pc 32 its PC; if_valid 1 fetch slot valid; flush 1 branch/jump redirect kill; hold 1 debug freeze (step mode); ex_rd 5 and ex_memread 1 and ex_valid 1 describing the EX-stage instruction.
REQ-003 SHALL have outputs: rs1 5, rs2 5, rd 5 (drive register-file A1/A2/A3 paths); rf_we 1; mem_read 1; mem_write 1; branch 1; jump 1; imm 32; id_pc 32; id_instr 32; id_valid 1; illegal 1; stall_o 1 (to fetch); stall_cnt 16.

Function
REQ-004 SHALL hold an IF/ID register {instr, pc, valid}; next-state priority: reset > flush > (load_use or hold) > load.
REQ-005 On load: instr<=if_instr, pc<=if_pc, valid<=if_valid; if_valid=0 SHALL load instr=0x00000013 (NOP).
REQ-006 On flush: valid<=0, instr<=0x00000013, pc unchanged.
REQ-007 On load_use or hold (no flush): register SHALL keep its value.
REQ-008 Latency: an instruction sampled on edge n SHALL appear on all decode outputs during cycle n+1 (decode is combinational from the register).
REQ-009 rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], always, id_pc=pc, id_instr=instr.
REQ-010 Decoded opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-011 rf_we=1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC only when rd!=0; rd==0 SHALL give rf_we=0.
REQ-012 mem_read=LOAD; mem_write=STORE; branch=BRANCH; jump=JAL|JALR.
REQ-013 imm: I-type (I-ALU, LOAD, JALR) sext(instr[31:20]); S sext{[31:25],[11:7]}; B sext{[31],[7],[30:25],[11:8],0}; U {[31:12],12'h0}; J sext{[31],[19:12],[20],[30:21],0}; R and illegal 0.
REQ-014 uses_rs1 = R|I-ALU|LOAD|STORE|BRANCH|JALR; uses_rs2 = R|STORE|BRANCH.
REQ-015 load_use = valid & ex_valid & ex_memread & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
REQ-016 stall_o = (load_use | hold) & ~flush.
REQ-017 bubble = ~valid | load_use | hold | flush; when bubble, rf_we, mem_read, mem_write, branch, jump, id_valid, illegal SHALL be 0; else id_valid=1.
REQ-018 illegal=1 when not bubble and opcode not in REQ-010; all control outputs 0 then.
REQ-019 stall_cnt SHALL increment by 1 each cycle load_use=1 and flush=0, saturating at 0xFFFF (no wrap).
REQ-020 flush and load_use in same cycle: flush SHALL win (register flushed, no stall, no count).

Reset
REQ-021 When rst=0 at a clk rising edge: instr=0x00000013, pc=0, valid=0, stall_cnt=0; outputs then: id_valid=0, all control 0, stall_o=hold, imm=0, rs1=rs2=rd=0.
REQ-022 Reset asserted mid-stall SHALL clear the held instruction; first valid instruction after rst=1 loads on the next edge.

Verification
REQ-023 Reset then if_instr=0x00500093 (addi x1,x0,5), if_pc=0x10, if_valid=1 -> next cycle rs1=0, rd=1, imm=5, rf_we=1, id_pc=0x10, id_valid=1.
REQ-024 Load-use: register holds 0x002081B3 (add x3,x1,x2), ex_rd=2, ex_memread=1, ex_valid=1 -> stall_o=1, rf_we=0, id_valid=0, register unchanged next cycle, stall_cnt +1; ex_memread=0 -> instruction issues, rf_we=1.
REQ-025 Flush with load_use active -> next cycle id_valid=0, id_instr=0x00000013, stall_o=0, stall_cnt unchanged.
REQ-026 Immediates: 0xFE112E23 (sw x1,-4(x2)) -> imm=0xFFFFFFFC, mem_write=1, rf_we=0; 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1; 0x000010B7 (lui x1,1) -> imm=0x00001000.
REQ-027 rd==0: 0x00000033 -> rf_we=0, id_valid=1; opcode 0x7F -> illegal=1, all control 0.
REQ-028 Force 65536+ consecutive load_use cycles -> stall_cnt stays 0xFFFF; hold=1 alone -> stall_o=1, stall_cnt unchanged.
